// File: rtl/version_writer_if.sv
// version_writer_if: write stream, pin inputs and slot outputs of version_writer.
// The master side is the producer/reader pair; the slave side is version_writer.
interface version_writer_if #(
    parameter int BLOCK_SIZE = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  writeValid;
    logic [DATA_WIDTH-1:0] writeData;
    logic                  writeReady;
    logic                  pinValid;
    logic [BLOCK_SIZE-1:0] pinVersion;
    logic [DATA_WIDTH-1:0] dataOut0;
    logic [DATA_WIDTH-1:0] dataOut1;
    logic [DATA_WIDTH-1:0] dataOut2;
    logic [DATA_WIDTH-1:0] dataOut3;
    logic [BLOCK_SIZE-1:0] versionOut0;
    logic [BLOCK_SIZE-1:0] versionOut1;
    logic [BLOCK_SIZE-1:0] versionOut2;
    logic [BLOCK_SIZE-1:0] versionOut3;
    logic [3:0]            slotValid;
    logic [BLOCK_SIZE-1:0] currentVersion;
    logic                  stalled;

    modport master (
        output writeValid, writeData, pinValid, pinVersion,
        input  writeReady, dataOut0, dataOut1, dataOut2, dataOut3,
               versionOut0, versionOut1, versionOut2, versionOut3,
               slotValid, currentVersion, stalled
    );

    modport slave (
        input  writeValid, writeData, pinValid, pinVersion,
        output writeReady, dataOut0, dataOut1, dataOut2, dataOut3,
               versionOut0, versionOut1, versionOut2, versionOut3,
               slotValid, currentVersion, stalled
    );
endinterface

// File: rtl/version_writer.sv
// version_writer: tags each accepted word with a wrapping, never-zero version
// and keeps the four most recent versions in a ring of slots.
// Optional feature macro: PIN_PROTECT_EN (eviction guard on the oldest slot
// plus the registered stalled flag). Without it, pin inputs are ignored.
module version_writer #(
    parameter int BLOCK_SIZE = 4,
    parameter int DATA_WIDTH = 32
) (
    input logic             clk,
    input logic             rst,
    version_writer_if.slave bus
);

    typedef enum logic {
        FILL,
        STEADY
    } state_t;

    localparam logic [BLOCK_SIZE-1:0] VER_ONE = BLOCK_SIZE'(1);
    localparam logic [BLOCK_SIZE-1:0] VER_MAX = '1;

    state_t                state;
    state_t                state_next;
    logic [1:0]            wr_ptr;
    logic [BLOCK_SIZE-1:0] next_version;
    logic [BLOCK_SIZE-1:0] current_version;
    logic [DATA_WIDTH-1:0] slot_data [4];
    logic [BLOCK_SIZE-1:0] slot_ver  [4];
    logic [3:0]            slot_valid;
    logic                  ready;
    logic                  transfer;
    logic                  pin_block;

`ifdef PIN_PROTECT_EN
    logic stalled_q;

    // A live pin on the version about to be evicted blocks the write.
    always_comb begin
        pin_block = bus.pinValid && (slot_ver[wr_ptr] == bus.pinVersion);
    end

    // Remember that the previous edge saw a refused request.
    always_ff @(posedge clk) begin
        if (rst) begin
            stalled_q <= 1'b0;
        end else begin
            stalled_q <= bus.writeValid && !ready;
        end
    end

    assign bus.stalled = stalled_q;
`else
    logic unused_pin;

    assign unused_pin  = bus.pinValid | (|bus.pinVersion);
    assign pin_block   = 1'b0;
    assign bus.stalled = 1'b0;
`endif

    // Ready: always open while filling; in steady state only the pin can close it.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        ready = !rst;
        if (state == STEADY) begin
            ready = !rst && !pin_block;
        end
    end

    assign transfer = bus.writeValid && ready;

    // Next state: leave FILL on the write that occupies the last empty slot.
    always_comb begin
        state_next = state;
        case (state)
            FILL: begin
                if (transfer && (&(slot_valid | (4'b0001 << wr_ptr)))) begin
                    state_next = STEADY;
                end
            end
            STEADY:  state_next = STEADY;
            default: state_next = FILL;
        endcase
    end

    // State register; reset is the only way back to FILL.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Slot ring, write pointer and version counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            next_version    <= VER_ONE;
            current_version <= '0;
            slot_valid      <= '0;
            // NOTE: the slot storage is reset on purpose; empty slots must read as data 0 / version 0.
            for (int i = 0; i < 4; i++) begin
                slot_data[i] <= '0;
                slot_ver[i]  <= '0;
            end
        end else if (transfer) begin
            slot_data[wr_ptr]  <= bus.writeData;
            slot_ver[wr_ptr]   <= next_version;
            slot_valid[wr_ptr] <= 1'b1;
            current_version    <= next_version;
            wr_ptr             <= wr_ptr + 2'd1;
            // Version 0 means empty, so the counter wraps from all-ones back to 1.
            next_version       <= (next_version == VER_MAX) ? VER_ONE : next_version + VER_ONE;
        end
    end

    assign bus.writeReady     = ready;
    assign bus.dataOut0       = slot_data[0];
    assign bus.dataOut1       = slot_data[1];
    assign bus.dataOut2       = slot_data[2];
    assign bus.dataOut3       = slot_data[3];
    assign bus.versionOut0    = slot_ver[0];
    assign bus.versionOut1    = slot_ver[1];
    assign bus.versionOut2    = slot_ver[2];
    assign bus.versionOut3    = slot_ver[3];
    assign bus.slotValid      = slot_valid;
    assign bus.currentVersion = current_version;

endmodule

// File: doc/version_writer.md
# version_writer

Write-side companion to `priorityRouter`. It accepts a stream of 32-bit data words and assigns each one a monotonically increasing version tag. It stores the last four versions in four slots and presents them as `dataOut0..3` / `versionOut0..3`, wired directly to the router's `dataIn0..3` / `version0..3`. An optional pin input blocks eviction of the oldest slot while a reader still needs it.

## Interface
- `BLOCK_SIZE`, default 4: version tag width in bits.
- `DATA_WIDTH`, default 32: data word width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `writeValid`  in  1  a write request is present.
- `writeData`  in  DATA_WIDTH  word to store.
- `writeReady`  out  1  block accepts the request this cycle.
- `pinValid`  in  1  `pinVersion` is live.
- `pinVersion`  in  BLOCK_SIZE  oldest version a reader still requires.
- `dataOut0..3`  out  DATA_WIDTH each  slot contents.
- `versionOut0..3`  out  BLOCK_SIZE each  slot version tags; 0 means empty.
- `slotValid`  out  4  per-slot occupancy; bit i corresponds to slot i.
- `currentVersion`  out  BLOCK_SIZE  most recently committed version; 0 before the first write.
- `stalled`  out  1  registered; high the cycle after a refused request.

## Operation
- Reset values: all `dataOut*` = 0, all `versionOut*` = 0, `slotValid` = 4'b0000, `currentVersion` = 0, `stalled` = 0.
- Internal reset values: `wrPtr` = 0, `nextVersion` = 1, FSM = FILL.
- Handshake: a transfer occurs on any edge where `writeValid && writeReady`. `writeData` is ignored otherwise.
- On a transfer, slot `wrPtr` receives:
  - data = `writeData`
  - version = `nextVersion`
  - valid = 1
- Also on a transfer:
  - `currentVersion` <= `nextVersion`
  - `wrPtr` <= (`wrPtr`+1) mod 4
  - `nextVersion` advances.
- Version arithmetic: `nextVersion` increments modulo 2^BLOCK_SIZE but skips 0, because 0 is reserved for "empty". With BLOCK_SIZE = 4 the sequence is 1..15, 1, ...
- FSM:
  - FILL: at least one slot is empty. `writeReady` = 1 whenever not in reset.
  - FILL -> STEADY on the transfer that sets the fourth valid bit.
  - STEADY: all slots valid, and every write evicts slot `wrPtr`, which is the oldest. STEADY is left only through reset.
- Eviction guard (STEADY only): `writeReady` = !(`pinValid` && `versionOut[wrPtr]` == `pinVersion`). This is combinational from the pin inputs.
- `stalled` <= `writeValid && !writeReady` on every edge.
- Reset takes priority over a simultaneous transfer; the request is dropped.
- Reset mid-stream clears all slots, and the next accepted write is tagged 1 in slot 0.

## Timing
- Write latency is 1 cycle. A word accepted at edge N appears on its slot outputs and `currentVersion` after edge N.
- Throughput is one write per cycle when not stalled.
- `writeReady` responds combinationally to `pinValid`/`pinVersion` in the same cycle; there are no registered pin inputs.
- A request that is stalled must be held by the source, with `writeValid` high and `writeData` stable, until accepted.
- Releasing the pin, by deasserting `pinValid` or changing `pinVersion`, makes `writeReady` high in that same cycle.

## Configuration
- `PIN_PROTECT_EN` defined: eviction guard and `stalled` behave as described above.
- `PIN_PROTECT_EN` not defined:
  - `pinValid`/`pinVersion` are ignored.
  - `writeReady` = !`rst` in all states.
  - `stalled` is tied to 0.
  - STEADY always overwrites the oldest slot.

## Test plan
- Reset, then write 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles:
  - result: slots 0..3 hold those words with versions 1..4, `slotValid` = 4'b1111, `currentVersion` = 4.
- Continue with a fifth write 0xA4:
  - result: slot 0 = 0xA4 / version 5, `wrPtr` = 1, slots 1..3 unchanged.
- Write 17 words after reset (BLOCK_SIZE 4):
  - result: versions run 1..15, then 1, 2 with 0 never issued; `currentVersion` = 2 at the end.
- `PIN_PROTECT_EN` set, STEADY with slot 0 holding version 5, `pinValid` = 1, `pinVersion` = 5, `writeValid` = 1:
  - result: `writeReady` = 0, `stalled` = 1 next cycle, slots unchanged.
  - Drop `pinValid`: write is accepted that cycle with version 9.
- Assert `rst` together with an accepted write after three writes:
  - result: the write is dropped and all outputs return to reset values.
  - The next write lands in slot 0 with version 1.
- `PIN_PROTECT_EN` undefined, same pin stimulus as the pin-stall scenario:
  - result: the write is accepted immediately and `stalled` stays 0.
